divisor_segmentado_param: RTL and testbench

//  Fully pipelined signed/unsigned integer divider: quotient and remainder of Num/Den.

---
 rtl/divisor_pkg.sv | 32 +++
 rtl/divisor_segmentado_param_if.sv | 25 ++
 rtl/divisor_etapa.sv | 58 +++++
 rtl/divisor_segmentado_param.sv | 117 +++++++++++
 tb/tb_divisor_segmentado_param.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/divisor_pkg.sv
// Shared types and helpers for the pipelined restoring divider.
// Stage payload widths depend on TAMANYO, so only the width-free parts live here.
package divisor_pkg;

  // Widest operand the abs helper handles; wider dividers need this raised.
  localparam int unsigned ANCHO_MAX = 64;

  // Flags that travel unchanged alongside the data through every stage.
  typedef struct packed {
    logic valid;
    logic sign_q;
    logic sign_r;
    logic zero;
  } stage_flags_t;

  // Packed width of one stage word: flags + |Den| + partial remainder (W+1) + quotient/dividend.
  function automatic int unsigned stage_bits(input int unsigned tam);
    return 3 * tam + 5;
  endfunction

  // Two's-complement magnitude; callers truncate back to their own width.
  function automatic logic [ANCHO_MAX-1:0] abs_c2(input logic [ANCHO_MAX-1:0] x,
                                                 input logic                 neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic bit params_ok(input int unsigned tam, input int unsigned bpe);
    return (tam >= 4) && (tam <= ANCHO_MAX) && (bpe >= 1) && (bpe <= tam) &&
           ((tam % bpe) == 0);
  endfunction

endpackage

// File: rtl/divisor_segmentado_param_if.sv
// Operand/result bundle of the pipelined divider.
// The master drives operands and the stall enable; the slave (divider) returns results.
interface divisor_segmentado_param_if #(
  parameter int unsigned TAMANYO = 32
);
  logic               Ena;
  logic               Start;
  logic               Signo;
  logic [TAMANYO-1:0] Num;
  logic [TAMANYO-1:0] Den;
  logic [TAMANYO-1:0] Q;
  logic [TAMANYO-1:0] R;
  logic               DivCero;
  logic               Done;

  modport master (
    output Ena, Start, Signo, Num, Den,
    input  Q, R, DivCero, Done
  );

  modport slave (
    input  Ena, Start, Signo, Num, Den,
    output Q, R, DivCero, Done
  );
endinterface

// File: rtl/divisor_etapa.sv
// One registered restoring-division stage resolving BPE quotient bits.
// The q field holds the not-yet-consumed dividend bits on top and the new quotient bits below.
module divisor_etapa import divisor_pkg::*; #(
  parameter int unsigned TAMANYO = 32,
  parameter int unsigned BPE     = 1
) (
  input  logic                             CLK,
  input  logic                             RSTa,
  input  logic                             Ena,
  input  logic [stage_bits(TAMANYO)-1:0]   etapa_i,
  output logic [stage_bits(TAMANYO)-1:0]   etapa_o
);

  typedef struct packed {
    stage_flags_t       f;
    logic [TAMANYO-1:0] den;
    logic [TAMANYO:0]   rem;
    logic [TAMANYO-1:0] q;
  } stage_t;

  stage_t             ent;
  stage_t             sal_d;
  stage_t             sal_q;
  logic [TAMANYO:0]   rem_v;
  logic [TAMANYO:0]   den_ext;
  logic [TAMANYO-1:0] q_v;

  assign ent = stage_t'(etapa_i);

  always_comb begin
    rem_v   = ent.rem;
    q_v     = ent.q;
    den_ext = {1'b0, ent.den};
    for (int b = 0; b < BPE; b++) begin
      // Bring the next dividend bit into the remainder and free a quotient slot.
      rem_v = {rem_v[TAMANYO-1:0], q_v[TAMANYO-1]};
      q_v   = {q_v[TAMANYO-2:0], 1'b0};
      if (rem_v >= den_ext) begin
        rem_v  = rem_v - den_ext;
        q_v[0] = 1'b1;
      end
    end
    sal_d     = ent;
    sal_d.rem = rem_v;
    sal_d.q   = q_v;
  end

  always_ff @(posedge CLK) begin
    if (!RSTa) begin
      sal_q <= '0;
    end else if (Ena) begin
      sal_q <= sal_d;
    end
  end

  assign etapa_o = sal_q;

endmodule

// File: rtl/divisor_segmentado_param.sv
// Fully pipelined signed/unsigned divider: input stage, TAMANYO/BPE restoring stages, output stage.
// Every register, including the results, holds while Ena is low.
module divisor_segmentado_param import divisor_pkg::*; #(
  parameter int unsigned TAMANYO = 32,
  parameter int unsigned BPE     = 1
) (
  input  logic                       CLK,
  input  logic                       RSTa,
  divisor_segmentado_param_if.slave  bus
);

  localparam int unsigned NE  = TAMANYO / BPE;
  localparam int unsigned LAT = NE + 2;
  localparam int unsigned SW  = stage_bits(TAMANYO);

  if (!params_ok(TAMANYO, BPE) || (LAT != NE + 2)) begin : g_param_err
    $error("divisor_segmentado_param: TAMANYO must be >= 4 and a multiple of BPE");
  end

  typedef struct packed {
    stage_flags_t       f;
    logic [TAMANYO-1:0] den;
    logic [TAMANYO:0]   rem;
    logic [TAMANYO-1:0] q;
  } stage_t;

  // Input stage: magnitudes and sign bookkeeping.
  logic               neg_num;
  logic               neg_den;
  logic [TAMANYO-1:0] abs_num;
  logic [TAMANYO-1:0] abs_den;
  stage_t             entrada_d;
  stage_t             entrada_q;

  assign neg_num = bus.Signo & bus.Num[TAMANYO-1];
  assign neg_den = bus.Signo & bus.Den[TAMANYO-1];
  assign abs_num = TAMANYO'(abs_c2(ANCHO_MAX'(bus.Num), neg_num));
  assign abs_den = TAMANYO'(abs_c2(ANCHO_MAX'(bus.Den), neg_den));

  always_comb begin
    entrada_d          = '0;
    entrada_d.f.valid  = bus.Start;
    entrada_d.f.sign_q = neg_num ^ neg_den;
    entrada_d.f.sign_r = neg_num;
    entrada_d.f.zero   = (bus.Den == '0);
    entrada_d.den      = abs_den;
    entrada_d.q        = abs_num;
  end

  always_ff @(posedge CLK) begin
    if (!RSTa) begin
      entrada_q <= '0;
    end else if (bus.Ena) begin
      entrada_q <= entrada_d;
    end
  end

  // Division chain.
  logic [NE:0][SW-1:0] cadena;

  assign cadena[0] = entrada_q;

  for (genvar i = 0; i < NE; i++) begin : g_etapa
    divisor_etapa #(
      .TAMANYO (TAMANYO),
      .BPE     (BPE)
    ) u_etapa (
      .CLK     (CLK),
      .RSTa    (RSTa),
      .Ena     (bus.Ena),
      .etapa_i (cadena[i]),
      .etapa_o (cadena[i+1])
    );
  end

  // Output stage: restore signs. With Den=0 every quotient bit resolves to 1 and the remainder
  // ends up as |Num|, so re-signing it reproduces the original dividend.
  stage_t             ult;
  logic [TAMANYO-1:0] q_fin;
  logic [TAMANYO-1:0] r_fin;
  logic [TAMANYO-1:0] q_q;
  logic [TAMANYO-1:0] r_q;
  logic               divcero_q;
  logic               done_q;
  logic               unused_bits;

  assign ult         = stage_t'(cadena[NE]);
  assign unused_bits = ^{ult.den, ult.rem[TAMANYO]};

  always_comb begin
    q_fin = ult.f.sign_q ? (~ult.q + 1'b1) : ult.q;
    if (ult.f.zero) begin
      q_fin = '1;
    end
    r_fin = ult.f.sign_r ? (~ult.rem[TAMANYO-1:0] + 1'b1) : ult.rem[TAMANYO-1:0];
  end

  always_ff @(posedge CLK) begin
    if (!RSTa) begin
      q_q       <= '0;
      r_q       <= '0;
      divcero_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.Ena) begin
      q_q       <= q_fin;
      r_q       <= r_fin;
      divcero_q <= ult.f.valid & ult.f.zero;
      done_q    <= ult.f.valid;
    end
  end

  assign bus.Q       = q_q;
  assign bus.R       = r_q;
  assign bus.DivCero = divcero_q;
  assign bus.Done    = done_q;

endmodule

// File: tb/tb_divisor_segmentado_param.sv
// Bench for divisor_segmentado_param: directed vector table, random stall stream, reset flush.
module tb_divisor_segmentado_param;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 2;

  logic clk;
  logic rsta;
  int   checks;
  int   errors;

  divisor_segmentado_param_if #(.TAMANYO(W)) bus ();

  divisor_segmentado_param #(
    .TAMANYO (W),
    .BPE     (1)
  ) dut (
    .CLK  (clk),
    .RSTa (rsta),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          signo;
    logic [W-1:0]  num;
    logic [W-1:0]  den;
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic          dz;
  } vec_t;

  vec_t tabla [14];

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference using native signed/unsigned division.
  function automatic void model(input logic s, input logic [W-1:0] n, input logic [W-1:0] d,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    longint sn;
    longint sd;
    dz = (d == '0);
    if (d == '0) begin
      q = '1;
      r = n;
    end else if (s) begin
      sn = longint'($signed(n));
      sd = longint'($signed(d));
      q  = W'(sn / sd);
      r  = W'(sn % sd);
    end else begin
      q = n / d;
      r = n % d;
    end
  endfunction

  // One isolated operation: latency, results, and a single-cycle Done.
  task automatic run_one(input vec_t v, input int idx);
    int n;
    bit got;
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Signo = v.signo;
    bus.Num   = v.num;
    bus.Den   = v.den;
    n   = 0;
    got = 1'b0;
    while (!got && n < int'(LAT) + 8) begin
      @(posedge clk);
      #1;
      n++;
      bus.Start = 1'b0;
      if (bus.Done) got = 1'b1;
    end
    chk($sformatf("v%0d latency", idx), 68'(n), 68'(LAT));
    chk($sformatf("v%0d Q", idx), 68'(bus.Q), 68'(v.q));
    chk($sformatf("v%0d R", idx), 68'(bus.R), 68'(v.r));
    chk($sformatf("v%0d DivCero", idx), 68'(bus.DivCero), 68'(v.dz));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d Done one cycle", idx), 68'(bus.Done), 68'(0));
  endtask

  initial begin
    logic [W-1:0] mq [$];
    logic [W-1:0] mr [$];
    logic         mz [$];
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    logic [67:0]  snap;
    logic [W-1:0] rn;
    logic [W-1:0] rd;
    logic         rs;
    bit           en;
    int           sent;
    int           recv;
    int           n;
    bit           got;
    bit           leak;

    checks = 0;
    errors = 0;

    tabla[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tabla[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    tabla[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
    tabla[3]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    tabla[4]  = '{1'b0, 32'd55,         32'd0,          32'hFFFFFFFF,   32'd55,         1'b1};
    tabla[5]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    tabla[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    tabla[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    tabla[8]  = '{1'b1, 32'hFFFFFFC9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFC9,   1'b1};
    tabla[9]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    tabla[10] = '{1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
    tabla[11] = '{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0};
    tabla[12] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    tabla[13] = '{1'b1, 32'd7,          32'hFFFFFF9C,   32'd0,          32'd7,          1'b0};

    // Reset with Ena high.
    rsta      = 1'b0;
    bus.Ena   = 1'b1;
    bus.Start = 1'b1;
    bus.Signo = 1'b0;
    bus.Num   = 32'd100;
    bus.Den   = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("reset Done", 68'(bus.Done), 68'(0));
    chk("reset Q", 68'(bus.Q), 68'(0));
    chk("reset R", 68'(bus.R), 68'(0));
    chk("reset DivCero", 68'(bus.DivCero), 68'(0));
    @(negedge clk);
    bus.Start = 1'b0;
    rsta      = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) run_one(tabla[i], i);

    // Back-to-back stream with pseudo-random stalls against the reference model.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 1000 && recv < 40; cyc++) begin
      @(negedge clk);
      en      = ($urandom_range(0, 3) != 0);
      bus.Ena = en;
      if (sent < 40) begin
        rs = 1'($urandom_range(0, 1));
        rn = $urandom;
        rd = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 20)) : $urandom;
        if (rs && $urandom_range(0, 3) == 0) rd = W'($urandom_range(0, 9)) ^ '1;
        bus.Start = 1'b1;
        bus.Signo = rs;
        bus.Num   = rn;
        bus.Den   = rd;
        if (en) begin
          model(rs, rn, rd, eq, er, ez);
          mq.push_back(eq);
          mr.push_back(er);
          mz.push_back(ez);
          sent++;
        end
      end else begin
        bus.Start = 1'b0;
      end
      snap = {bus.Q, bus.R, 2'b00, bus.DivCero, bus.Done};
      @(posedge clk);
      #1;
      if (!en) begin
        chk("stall frozen", {bus.Q, bus.R, 2'b00, bus.DivCero, bus.Done}, snap);
      end else if (bus.Done) begin
        if (mq.size() == 0) begin
          chk("stream unexpected Done", 68'(1), 68'(0));
        end else begin
          chk($sformatf("stream%0d Q", recv), 68'(bus.Q), 68'(mq.pop_front()));
          chk($sformatf("stream%0d R", recv), 68'(bus.R), 68'(mr.pop_front()));
          chk($sformatf("stream%0d DivCero", recv), 68'(bus.DivCero), 68'(mz.pop_front()));
        end
        recv++;
      end
    end
    chk("stream Done count", 68'(recv), 68'(sent));
    chk("stream Start count", 68'(sent), 68'(40));

    // Reset with 10 ops in flight, asserted while Ena is low.
    @(negedge clk);
    bus.Ena = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.Start = 1'b1;
      bus.Signo = 1'b0;
      bus.Num   = W'(100 + k);
      bus.Den   = 32'd3;
      @(negedge clk);
    end
    bus.Start = 1'b0;
    bus.Ena   = 1'b0;
    rsta      = 1'b0;
    @(posedge clk);
    #1;
    chk("flush Done", 68'(bus.Done), 68'(0));
    chk("flush Q", 68'(bus.Q), 68'(0));
    chk("flush R", 68'(bus.R), 68'(0));
    @(negedge clk);
    rsta    = 1'b1;
    bus.Ena = 1'b1;
    leak    = 1'b0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (bus.Done) leak = 1'b1;
    end
    chk("flush no stale Done", 68'(leak), 68'(0));

    @(negedge clk);
    bus.Start = 1'b1;
    bus.Signo = 1'b0;
    bus.Num   = 32'd9;
    bus.Den   = 32'd3;
    n   = 0;
    got = 1'b0;
    while (!got && n < int'(LAT) + 8) begin
      @(posedge clk);
      #1;
      n++;
      bus.Start = 1'b0;
      if (bus.Done) got = 1'b1;
    end
    chk("post-reset latency", 68'(n), 68'(LAT));
    chk("post-reset Q", 68'(bus.Q), 68'(3));
    chk("post-reset R", 68'(bus.R), 68'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
